// File: rtl/uart_rx_if.sv
// Receiver-side bundle between the serial line, the UART receiver and the debug unit.
// The master modport is the receiver; the slave modport is the line driver / byte consumer.
interface uart_rx_if #(
  parameter int unsigned NB_DATA = 8
);
  logic               rx;
  logic [NB_DATA-1:0] rx_data;
  logic               rx_done;
  logic               frame_error;
  logic               busy;

  modport master (
    input  rx,
    output rx_data,
    output rx_done,
    output frame_error,
    output busy
  );

  modport slave (
    output rx,
    input  rx_data,
    input  rx_done,
    input  frame_error,
    input  busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling tick generator, two-flop input synchroniser
// and framing-error detection. Bytes are reported as one-cycle strobes to the debug unit.
module uart_rx #(
  parameter int unsigned NB_DATA   = 8,
  parameter int unsigned SB_TICK   = 16,
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD_RATE = 19200
) (
  input  logic      i_clock,
  input  logic      i_reset,
  uart_rx_if.master bus
);

  localparam int unsigned DIVISOR = CLK_FREQ / (BAUD_RATE * 16);
  localparam int unsigned NB_DIV  = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int unsigned SMax    = (SB_TICK > 16) ? SB_TICK : 16;
  localparam int unsigned NB_S    = $clog2(SMax);
  localparam int unsigned NB_N    = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  localparam logic [NB_DIV-1:0] DivLast   = NB_DIV'(DIVISOR - 1);
  localparam logic [NB_S-1:0]   SStartMid = NB_S'(7);
  localparam logic [NB_S-1:0]   SBitLast  = NB_S'(15);
  localparam logic [NB_S-1:0]   SStopMid  = NB_S'(SB_TICK - 1);
  localparam logic [NB_N-1:0]   NLast     = NB_N'(NB_DATA - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } state_e;

  state_e             state_q, state_d;
  logic [NB_DIV-1:0]  div_q, div_d;
  logic               tick;
  logic [NB_S-1:0]    s_q, s_d;
  logic [NB_N-1:0]    n_q, n_d;
  logic [NB_DATA-1:0] shift_q, shift_d;
  logic [NB_DATA-1:0] rx_data_q, rx_data_d;
  logic               done_q, done_d;
  logic               ferr_q, ferr_d;
  logic               rx_meta_q, rx_s_q;

  // Free-running; deliberately not re-phased on the start edge.
  always_comb begin
    tick  = (div_q == DivLast);
    div_d = tick ? '0 : div_q + 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    n_d       = n_q;
    shift_d   = shift_q;
    rx_data_d = rx_data_q;
    done_d    = 1'b0;
    ferr_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!rx_s_q) begin
          state_d = StStart;
          s_d     = '0;
        end
      end

      StStart: begin
        if (tick) begin
          if (s_q == SStartMid) begin
            if (!rx_s_q) begin
              state_d = StData;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      StData: begin
        if (tick) begin
          if (s_q == SBitLast) begin
            s_d     = '0;
            shift_d = {rx_s_q, shift_q[NB_DATA-1:1]};
            if (n_q == NLast) begin
              state_d = StStop;
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      StStop: begin
        if (tick) begin
          if (s_q == SStopMid) begin
            if (rx_s_q) begin
              rx_data_d = shift_q;
              done_d    = 1'b1;
              state_d   = StIdle;
            end else begin
              ferr_d  = 1'b1;
              state_d = StBreak;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      // A line held low must return high before another start edge is accepted.
      StBreak: begin
        if (rx_s_q) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q   <= StIdle;
      div_q     <= '0;
      s_q       <= '0;
      n_q       <= '0;
      shift_q   <= '0;
      rx_data_q <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      s_q       <= s_d;
      n_q       <= n_d;
      shift_q   <= shift_d;
      rx_data_q <= rx_data_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
      rx_meta_q <= bus.rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign bus.rx_data     = rx_data_q;
  assign bus.rx_done     = done_q;
  assign bus.frame_error = ferr_q;
  assign bus.busy        = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at DIVISOR=4 (64 clocks per bit): single frames, back-to-back
// frames, glitch rejection, framing error with break, mid-frame reset and latency.
module tb_uart_rx;

  localparam int unsigned Bit = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  uart_rx_if #(.NB_DATA(8)) rx_if ();

  uart_rx #(
    .NB_DATA  (8),
    .SB_TICK  (16),
    .CLK_FREQ (1000000),
    .BAUD_RATE(15625)
  ) dut (
    .i_clock(clk),
    .i_reset(rst_n),
    .bus    (rx_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int         done_edges = 0;
  int         done_hi = 0;
  int         ferr_edges = 0;
  int         ferr_hi = 0;
  int         both_hi = 0;
  logic       prev_done = 1'b0;
  logic       prev_ferr = 1'b0;
  logic [7:0] rec_data [64];
  int         rec_cyc  [64];

  always @(posedge clk) cyc <= cyc + 1;

  // Observes the strobes on the falling edge, away from the active edge.
  always @(negedge clk) begin
    prev_done <= rx_if.rx_done;
    prev_ferr <= rx_if.frame_error;
    if (rx_if.rx_done) done_hi <= done_hi + 1;
    if (rx_if.frame_error) ferr_hi <= ferr_hi + 1;
    if (rx_if.rx_done && rx_if.frame_error) both_hi <= both_hi + 1;
    if (rx_if.rx_done && !prev_done) begin
      if (done_edges < 64) begin
        rec_data[done_edges] <= rx_if.rx_data;
        rec_cyc[done_edges]  <= cyc;
      end
      done_edges <= done_edges + 1;
    end
    if (rx_if.frame_error && !prev_ferr) ferr_edges <= ferr_edges + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Called on a falling edge; drives one full 8N1 frame, LSB first.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx_if.rx = 1'b0;
    repeat (Bit) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_if.rx = b[i];
      repeat (Bit) @(negedge clk);
    end
    rx_if.rx = stop_bit;
    repeat (Bit) @(negedge clk);
  endtask

  int base;
  int fbase;
  int t0;

  initial begin
    rx_if.rx = 1'b1;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rx_data", 32'(rx_if.rx_data), 32'h00);
    chk("reset_rx_done", 32'(rx_if.rx_done), 32'h0);
    chk("reset_frame_error", 32'(rx_if.frame_error), 32'h0);
    chk("reset_busy", 32'(rx_if.busy), 32'h0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_busy", 32'(rx_if.busy), 32'h0);

    // 1: single frame
    base  = done_edges;
    fbase = ferr_edges;
    send_frame(8'h01, 1'b1);
    repeat (40) @(negedge clk);
    chk("t1_done_count", 32'(done_edges - base), 32'd1);
    chk("t1_rec_data", 32'(rec_data[base]), 32'h01);
    chk("t1_rx_data", 32'(rx_if.rx_data), 32'h01);
    chk("t1_ferr_count", 32'(ferr_edges - fbase), 32'd0);
    chk("t1_pulse_width", 32'(done_hi), 32'(done_edges));
    chk("t1_busy", 32'(rx_if.busy), 32'h0);

    // 2: back-to-back frames
    base = done_edges;
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    repeat (40) @(negedge clk);
    chk("t2_done_count", 32'(done_edges - base), 32'd2);
    chk("t2_first", 32'(rec_data[base]), 32'hA5);
    chk("t2_second", 32'(rec_data[base + 1]), 32'h3C);
    chk_range("t2_gap", rec_cyc[base + 1] - rec_cyc[base], 636, 644);
    chk("t2_rx_data", 32'(rx_if.rx_data), 32'h3C);

    // 3: short glitch
    base  = done_edges;
    fbase = ferr_edges;
    rx_if.rx = 1'b0;
    repeat (16) @(negedge clk);
    rx_if.rx = 1'b1;
    repeat (64) @(negedge clk);
    chk("t3_done_count", 32'(done_edges - base), 32'd0);
    chk("t3_ferr_count", 32'(ferr_edges - fbase), 32'd0);
    chk("t3_busy", 32'(rx_if.busy), 32'h0);

    // 4: framing error followed by a break, then a good frame
    base  = done_edges;
    fbase = ferr_edges;
    send_frame(8'h55, 1'b0);
    repeat (300) @(negedge clk);
    chk("t4_ferr_count", 32'(ferr_edges - fbase), 32'd1);
    chk("t4_done_count", 32'(done_edges - base), 32'd0);
    chk("t4_rx_data_held", 32'(rx_if.rx_data), 32'h3C);
    chk("t4_busy_in_break", 32'(rx_if.busy), 32'h1);
    rx_if.rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("t4_busy_after_break", 32'(rx_if.busy), 32'h0);
    send_frame(8'h07, 1'b1);
    repeat (40) @(negedge clk);
    chk("t4_done_count_after", 32'(done_edges - base), 32'd1);
    chk("t4_rx_data_after", 32'(rx_if.rx_data), 32'h07);
    chk("t4_ferr_count_after", 32'(ferr_edges - fbase), 32'd1);

    // 5: reset after four data bits of 0xFF
    base  = done_edges;
    fbase = ferr_edges;
    rx_if.rx = 1'b0;
    repeat (Bit) @(negedge clk);
    rx_if.rx = 1'b1;
    repeat (4 * Bit) @(negedge clk);
    chk("t5_busy_mid_frame", 32'(rx_if.busy), 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t5_rx_data_reset", 32'(rx_if.rx_data), 32'h00);
    chk("t5_busy_reset", 32'(rx_if.busy), 32'h0);
    chk("t5_done_reset", 32'(rx_if.rx_done), 32'h0);
    chk("t5_ferr_reset", 32'(rx_if.frame_error), 32'h0);
    repeat (700) @(negedge clk);
    chk("t5_aborted_done", 32'(done_edges - base), 32'd0);
    chk("t5_aborted_ferr", 32'(ferr_edges - fbase), 32'd0);
    send_frame(8'h08, 1'b1);
    repeat (40) @(negedge clk);
    chk("t5_done_count", 32'(done_edges - base), 32'd1);
    chk("t5_rx_data", 32'(rx_if.rx_data), 32'h08);

    // 6: latency from falling edge to strobe
    base = done_edges;
    t0   = cyc;
    send_frame(8'h80, 1'b1);
    repeat (40) @(negedge clk);
    chk("t6_done_count", 32'(done_edges - base), 32'd1);
    chk("t6_rx_data", 32'(rec_data[base]), 32'h80);
    chk_range("t6_latency", rec_cyc[base] - t0, 604, 616);

    chk("final_done_width", 32'(done_hi), 32'(done_edges));
    chk("final_ferr_width", 32'(ferr_hi), 32'(ferr_edges));
    chk("final_never_both", 32'(both_hi), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
